dpu_window_feeder: RTL and testbench

- Producer side of the DPU operand interface.
- Accepts a raster-order image pixel stream and a KERNEL_DEPTH-word kernel.
- Forms KERNEL_SIZE x KERNEL_SIZE sliding windows using line buffers plus a window shift register.
- Drives the DPU's in1/in2 vectors, we, done and part_sum, one valid-window strobe per output position (stride 1, no padding).

---
 rtl/dpu_feeder_pkg.sv | 16 +
 rtl/dpu_line_buffer.sv | 30 +++
 rtl/dpu_window_feeder.sv | 207 ++++++++++++++++++++
 tb/tb_dpu_window_feeder.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/dpu_feeder_pkg.sv
// Shared types and width helpers for the DPU window feeder.
package dpu_feeder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_K = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } feeder_state_e;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dpu_line_buffer.sv
// One image row of delay: a shift FIFO that advances only on pixel accept.
// dout_o is the pixel pushed DEPTH accepts ago.
module dpu_line_buffer
  import dpu_feeder_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  assign dout_o = mem_q[DEPTH-1];

  // Shift the whole row by one position per accepted pixel.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (shift_i) begin
      mem_q[0] <= din_i;
      for (int i = 1; i < DEPTH; i++) mem_q[i] <= mem_q[i-1];
    end
  end

endmodule

// File: rtl/dpu_window_feeder.sv
// Producer side of the DPU operand interface: loads a kernel, then turns a
// raster pixel stream into KERNEL_SIZE x KERNEL_SIZE windows (stride 1).
// Optional build macro DPU_FEEDER_BIAS_EN adds bias_in, latched on start and
// presented on part_sum for the frame; otherwise part_sum is tied to zero.
//
// state  | meaning
// IDLE   | waiting for start; pixel and kernel inputs ignored
// LOAD_K | accepting KERNEL_DEPTH kernel words, no backpressure
// STREAM | pix_ready=1, shifting pixels, strobing we per full window
// DONE   | frame finished, done held until the next start
module dpu_window_feeder
  import dpu_feeder_pkg::*;
#(
  parameter int IMAGE_PIXEL_WIDTH  = 8,
  parameter int KERNEL_PIXEL_WIDTH = 8,
  parameter int KERNEL_SIZE        = 3,
  parameter int IMG_WIDTH          = 32,
  parameter int IMG_HEIGHT         = 32
) (
  input  logic                                         clock,
  input  logic                                         rst,
  input  logic                                         start,
  input  logic                                         kern_valid,
  input  logic [KERNEL_PIXEL_WIDTH-1:0]                kern_in,
  input  logic                                         pix_valid,
  input  logic [IMAGE_PIXEL_WIDTH-1:0]                 pix_in,
`ifdef DPU_FEEDER_BIAS_EN
  input  logic [IMAGE_PIXEL_WIDTH+KERNEL_PIXEL_WIDTH-1:0] bias_in,
`endif
  output logic                                         pix_ready,
  output logic [IMAGE_PIXEL_WIDTH-1:0]                 win_out  [KERNEL_SIZE*KERNEL_SIZE],
  output logic [KERNEL_PIXEL_WIDTH-1:0]                kern_out [KERNEL_SIZE*KERNEL_SIZE],
  output logic [IMAGE_PIXEL_WIDTH+KERNEL_PIXEL_WIDTH-1:0] part_sum,
  output logic                                         we,
  output logic                                         done,
  output logic                                         busy
);

  localparam int KERNEL_DEPTH = KERNEL_SIZE * KERNEL_SIZE;
  localparam int IPW = IMAGE_PIXEL_WIDTH;
  localparam int KPW = KERNEL_PIXEL_WIDTH;
  localparam int CW  = cnt_width(IMG_WIDTH);
  localparam int RW  = cnt_width(IMG_HEIGHT);
  localparam int KW  = cnt_width(KERNEL_DEPTH);

  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_WIDTH - 1);
  localparam logic [CW-1:0] COL_WIN   = CW'(KERNEL_SIZE - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_HEIGHT - 1);
  localparam logic [RW-1:0] ROW_WIN   = RW'(KERNEL_SIZE - 1);
  localparam logic [KW-1:0] KCNT_LAST = KW'(KERNEL_DEPTH - 1);

  feeder_state_e  state_q;
  logic [KW-1:0]  kcnt_q;
  logic [CW-1:0]  col_q;
  logic [RW-1:0]  row_q;
  logic           we_q, done_q, busy_q, pix_ready_q;
  logic [KPW-1:0] kern_q [KERNEL_DEPTH];
  logic [IPW-1:0] win_q  [KERNEL_DEPTH];
  logic [IPW-1:0] win_d  [KERNEL_DEPTH];
  logic [IPW-1:0] lb_dout [KERNEL_SIZE-1];
  logic [IPW-1:0] col_in  [KERNEL_SIZE];
  logic           accept;

  assign accept    = pix_valid & pix_ready_q;
  assign pix_ready = pix_ready_q;
  assign we        = we_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign win_out   = win_q;
  assign kern_out  = kern_q;

  // Line buffer g delays the stream by g+1 rows; the bottom window row is
  // the live pixel, rows above take progressively older line buffer taps.
  for (genvar g = 0; g < KERNEL_SIZE - 1; g++) begin : g_lb
    logic [IPW-1:0] din;
    if (g == 0) begin : g_first
      assign din = pix_in;
    end else begin : g_chain
      assign din = lb_dout[g-1];
    end
    dpu_line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(IPW)) u_lb (
      .clock  (clock),
      .rst    (rst),
      .shift_i(accept),
      .din_i  (din),
      .dout_o (lb_dout[g])
    );
  end

  for (genvar r = 0; r < KERNEL_SIZE; r++) begin : g_col
    if (r == KERNEL_SIZE - 1) begin : g_live
      assign col_in[r] = pix_in;
    end else begin : g_tap
      assign col_in[r] = lb_dout[KERNEL_SIZE-2-r];
    end
  end

  // Window shifts left one column per accept; new column enters on the right.
  always_comb begin
    win_d = win_q;
    if (accept) begin
      for (int r = 0; r < KERNEL_SIZE; r++) begin
        for (int c = 0; c < KERNEL_SIZE - 1; c++) begin
          win_d[r*KERNEL_SIZE+c] = win_q[r*KERNEL_SIZE+c+1];
        end
        win_d[r*KERNEL_SIZE+KERNEL_SIZE-1] = col_in[r];
      end
    end
  end

  // Window register.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < KERNEL_DEPTH; i++) win_q[i] <= '0;
    end else begin
      win_q <= win_d;
    end
  end

  // Sequencing FSM with its counters, kernel store and registered strobes.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      kcnt_q      <= '0;
      col_q       <= '0;
      row_q       <= '0;
      we_q        <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      pix_ready_q <= 1'b0;
      for (int i = 0; i < KERNEL_DEPTH; i++) kern_q[i] <= '0;
    end else begin
      we_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= LOAD_K;
            busy_q  <= 1'b1;
            kcnt_q  <= '0;
            col_q   <= '0;
            row_q   <= '0;
          end
        end
        LOAD_K: begin
          if (kern_valid) begin
            kern_q[kcnt_q] <= kern_in;
            if (kcnt_q == KCNT_LAST) begin
              state_q     <= STREAM;
              pix_ready_q <= 1'b1;
              kcnt_q      <= '0;
            end else begin
              kcnt_q <= kcnt_q + 1'b1;
            end
          end
        end
        STREAM: begin
          if (accept) begin
            we_q <= (row_q >= ROW_WIN) && (col_q >= COL_WIN);
            if (col_q == COL_LAST) begin
              col_q <= '0;
              if (row_q == ROW_LAST) begin
                state_q     <= DONE;
                pix_ready_q <= 1'b0;
                busy_q      <= 1'b0;
                row_q       <= '0;
              end else begin
                row_q <= row_q + 1'b1;
              end
            end else begin
              col_q <= col_q + 1'b1;
            end
          end
        end
        DONE: begin
          done_q <= 1'b1;
          if (start) begin
            state_q <= LOAD_K;
            done_q  <= 1'b0;
            busy_q  <= 1'b1;
            kcnt_q  <= '0;
            col_q   <= '0;
            row_q   <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef DPU_FEEDER_BIAS_EN
  logic [IPW+KPW-1:0] bias_q;

  // Bias is latched only when a start is actually accepted.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      bias_q <= '0;
    end else if (start && (state_q == IDLE || state_q == DONE)) begin
      bias_q <= bias_in;
    end
  end

  assign part_sum = bias_q;
`else
  assign part_sum = '0;
`endif

endmodule

// File: tb/tb_dpu_window_feeder.sv
// Directed bench for dpu_window_feeder on a 5x5 image with a 3x3 kernel.
module tb_dpu_window_feeder;

  logic        clock = 1'b0;
  logic        rst, start, kern_valid, pix_valid;
  logic [7:0]  kern_in, pix_in;
  logic        pix_ready, we, done, busy;
  logic [7:0]  win_out  [9];
  logic [7:0]  kern_out [9];
  logic [15:0] part_sum;
`ifdef DPU_FEEDER_BIAS_EN
  logic [15:0] bias_in;
`endif

  int vectors = 0;
  int miscompares = 0;
  logic [15:0] exp_ps = 16'h0000;

  always #5 clock = ~clock;

  dpu_window_feeder #(
    .IMAGE_PIXEL_WIDTH(8), .KERNEL_PIXEL_WIDTH(8), .KERNEL_SIZE(3),
    .IMG_WIDTH(5), .IMG_HEIGHT(5)
  ) dut (
    .clock(clock), .rst(rst), .start(start),
    .kern_valid(kern_valid), .kern_in(kern_in),
    .pix_valid(pix_valid), .pix_in(pix_in),
`ifdef DPU_FEEDER_BIAS_EN
    .bias_in(bias_in),
`endif
    .pix_ready(pix_ready), .win_out(win_out), .kern_out(kern_out),
    .part_sum(part_sum), .we(we), .done(done), .busy(busy)
  );

  task automatic check_vec(input string tag, input logic [71:0] got, input logic [71:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [71:0] pack9(input logic [7:0] a [9]);
    logic [71:0] p = '0;
    for (int i = 0; i < 9; i++) p = {p[63:0], a[i]};
    return p;
  endfunction

  // Window whose bottom-right pixel sits at (r, c); pixel value = r*5+c.
  function automatic logic [71:0] exp_win(input int r, input int c);
    logic [71:0] p = '0;
    for (int e = 0; e < 9; e++) p = {p[63:0], 8'((r - 2 + e / 3) * 5 + (c - 2 + e % 3))};
    return p;
  endfunction

  // Track last accepted pixel and capture every we window.
  logic       acc_prev = 1'b0;
  logic [7:0] last_pix = 8'd0;
  logic [71:0] wq[$];
  int          pq[$];

  always @(posedge clock) begin
    acc_prev <= pix_valid & pix_ready;
    last_pix <= pix_in;
  end

  always @(negedge clock) begin
    if (we === 1'b1) begin
      wq.push_back(pack9(win_out));
      pq.push_back(int'(last_pix));
      check_vec("we_after_accept", 72'(acc_prev), 72'd1);
      check_vec("part_sum_frame", 72'(part_sum), 72'(exp_ps));
    end
  end

  task automatic run_frame(input bit gaps, input bit krev, input bit start_mid, input int n_pix);
    int idx = 0;
    int cyc = 0;
    bit tog = 1'b1;
    bit will;
    wq.delete();
    pq.delete();
`ifdef DPU_FEEDER_BIAS_EN
    bias_in = 16'h00A5;
    exp_ps  = 16'h00A5;
`else
    exp_ps  = 16'h0000;
`endif
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    check_vec("busy_load", 72'(busy), 72'd1);
    check_vec("done_cleared", 72'(done), 72'd0);
    for (int k = 0; k < 9; k++) begin
      kern_valid = 1'b1;
      kern_in    = krev ? 8'(9 - k) : 8'(k + 1);
      @(posedge clock); #1;
    end
    kern_valid = 1'b0;
    check_vec("pix_ready_stream", 72'(pix_ready), 72'd1);
    while (idx < n_pix && cyc < 200) begin
      pix_valid = gaps ? tog : 1'b1;
      tog       = ~tog;
      pix_in    = 8'(idx);
      start     = start_mid && (idx == 8);
      will      = pix_valid & pix_ready;
      @(posedge clock); #1;
      start = 1'b0;
      if (will) idx++;
      cyc++;
    end
    pix_valid = 1'b0;
    check_vec("pix_accept_count", 72'(idx), 72'(n_pix));
    if (n_pix == 25) begin
      check_vec("last_we", 72'(we), 72'd1);
      check_vec("done_not_yet", 72'(done), 72'd0);
      check_vec("pix_ready_done", 72'(pix_ready), 72'd0);
      check_vec("busy_done", 72'(busy), 72'd0);
      @(posedge clock); #1;
      check_vec("done_rise", 72'(done), 72'd1);
      check_vec("we_after_last", 72'(we), 72'd0);
      repeat (3) @(posedge clock);
      #1;
      check_vec("done_held", 72'(done), 72'd1);
      check_vec("part_sum_end", 72'(part_sum), 72'(exp_ps));
      for (int k = 0; k < 9; k++)
        check_vec("kern_out", 72'(kern_out[k]), krev ? 72'(9 - k) : 72'(k + 1));
      check_vec("we_count", 72'(wq.size()), 72'd9);
      for (int i = 0; i < wq.size() && i < 9; i++) begin
        check_vec("window", wq[i], exp_win(2 + i / 3, 2 + i % 3));
        check_vec("window_pixel", 72'(pq[i]), 72'(5 * (2 + i / 3) + 2 + i % 3));
      end
      if (wq.size() >= 9) begin
        check_vec("first_window", wq[0], 72'h00_01_02_05_06_07_0A_0B_0C);
        check_vec("rowb_window", wq[3], 72'h05_06_07_0A_0B_0C_0F_10_11);
        check_vec("rowb_pixel", 72'(pq[3]), 72'd17);
        check_vec("last_window", wq[8], 72'h0C_0D_0E_11_12_13_16_17_18);
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; kern_valid = 1'b0; pix_valid = 1'b0;
    kern_in = 8'd0; pix_in = 8'd0;
`ifdef DPU_FEEDER_BIAS_EN
    bias_in = 16'h0000;
`endif
    repeat (2) @(posedge clock);
    #1;
    check_vec("rst_we", 72'(we), 72'd0);
    check_vec("rst_done", 72'(done), 72'd0);
    check_vec("rst_busy", 72'(busy), 72'd0);
    check_vec("rst_pix_ready", 72'(pix_ready), 72'd0);
    check_vec("rst_part_sum", 72'(part_sum), 72'd0);
    check_vec("rst_win", pack9(win_out), 72'd0);
    check_vec("rst_kern", pack9(kern_out), 72'd0);
    rst = 1'b0;
    @(posedge clock); #1;

    // IDLE ignores pixel and kernel traffic.
    pix_valid = 1'b1; kern_valid = 1'b1; kern_in = 8'h77; pix_in = 8'h33;
    repeat (3) @(posedge clock);
    #1;
    pix_valid = 1'b0; kern_valid = 1'b0;
    check_vec("idle_busy", 72'(busy), 72'd0);
    check_vec("idle_pix_ready", 72'(pix_ready), 72'd0);
    check_vec("idle_kern", pack9(kern_out), 72'd0);
    check_vec("idle_we", 72'(we), 72'd0);

    run_frame(1'b0, 1'b0, 1'b0, 25);   // basic
    run_frame(1'b0, 1'b1, 1'b0, 25);   // reversed kernel
    run_frame(1'b1, 1'b0, 1'b0, 25);   // gaps

    // Partial frame, then asynchronous reset mid-stream.
    run_frame(1'b0, 1'b0, 1'b0, 15);
    rst = 1'b1;
    #2;
    check_vec("midrst_we", 72'(we), 72'd0);
    check_vec("midrst_done", 72'(done), 72'd0);
    check_vec("midrst_pix_ready", 72'(pix_ready), 72'd0);
    check_vec("midrst_busy", 72'(busy), 72'd0);
    @(posedge clock); #1;
    rst = 1'b0;
    @(posedge clock); #1;
    check_vec("after_rst_done", 72'(done), 72'd0);

    // Restart with a stray start pulse during STREAM.
    run_frame(1'b0, 1'b0, 1'b1, 25);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
